// File: rtl/sys_cmd_pkg.sv
// Shared definitions for the system-controller command initiator: opcodes,
// request encodings, frame/response lengths and FSM states.
package sys_cmd_pkg;

    // Opcode byte leading each frame
    localparam logic [7:0] OPC_WR      = 8'hAA;
    localparam logic [7:0] OPC_RD      = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    // REQ_CMD encodings
    typedef enum logic [1:0] {
        CmdWr     = 2'b00,
        CmdRd     = 2'b01,
        CmdAluOp  = 2'b10,
        CmdAluNop = 2'b11
    } cmd_e;

    // Frame lengths in bytes, opcode included
    localparam int unsigned FRAME_LEN_WR      = 3;
    localparam int unsigned FRAME_LEN_RD      = 2;
    localparam int unsigned FRAME_LEN_ALU_OP  = 4;
    localparam int unsigned FRAME_LEN_ALU_NOP = 2;

    // Response lengths in bytes
    localparam int unsigned RSP_LEN_WR  = 0;
    localparam int unsigned RSP_LEN_RD  = 1;
    localparam int unsigned RSP_LEN_ALU = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitRsp
    } state_e;

    // Index of the last frame byte for a command
    function automatic logic [1:0] frame_last_idx(cmd_e cmd);
        case (cmd)
            CmdWr:    return 2'(FRAME_LEN_WR - 1);
            CmdRd:    return 2'(FRAME_LEN_RD - 1);
            CmdAluOp: return 2'(FRAME_LEN_ALU_OP - 1);
            default:  return 2'(FRAME_LEN_ALU_NOP - 1);
        endcase
    endfunction

    // Number of response bytes expected for a command
    function automatic int unsigned rsp_len(cmd_e cmd);
        case (cmd)
            CmdWr:   return RSP_LEN_WR;
            CmdRd:   return RSP_LEN_RD;
            default: return RSP_LEN_ALU;
        endcase
    endfunction

endpackage

// File: rtl/rsp_timer.sv
// Response inter-byte timeout counter. Counts enabled cycles since the last
// clear; expire_o flags the cycle on which the count steps onto
// TIMEOUT_CYCLES-1. A clear in the same cycle suppresses expiry.
// TIMEOUT_CYCLES must be at least 2.
module rsp_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntPreLast = CntW'(TIMEOUT_CYCLES - 2);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear dominates, saturate at the terminal value
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntLast)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == CntPreLast);

endmodule

// File: rtl/sys_cmd_initiator.sv
// Host-side initiator: serializes one command into the UART TX byte stream
// and, for read/ALU commands, assembles the RX response into one word.
module sys_cmd_initiator
    import sys_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ_VLD,
    output logic                    REQ_RDY,
    input  logic [1:0]              REQ_CMD,
    input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]   REQ_WR_DATA,
    input  logic [DATA_WIDTH-1:0]   REQ_OP_A,
    input  logic [DATA_WIDTH-1:0]   REQ_OP_B,
    input  logic [3:0]              REQ_FUN,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VLD,
    input  logic                    TX_BUSY,
    input  logic [DATA_WIDTH-1:0]   RX_DATA,
    input  logic                    RX_VLD,
    output logic [2*DATA_WIDTH-1:0] RSP_DATA,
    output logic                    RSP_VLD,
    output logic                    RSP_TIMEOUT,
    output logic                    BUSY
);

    state_e                  state_q;
    cmd_e                    cmd_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   opa_q;
    logic [DATA_WIDTH-1:0]   opb_q;
    logic [3:0]              fun_q;
    logic [1:0]              idx_q;
    logic                    rx_cnt_q;
    logic [DATA_WIDTH-1:0]   rx_lo_q;
    logic [2*DATA_WIDTH-1:0] rsp_data_q;
    logic                    rsp_vld_q;
    logic                    rsp_to_q;

    logic                    tx_accept;
    logic                    last_accept;
    logic                    rsp_final;
    logic                    tmr_clr;
    logic                    tmr_en;
    logic                    tmr_expire;
    logic [DATA_WIDTH-1:0]   tx_byte;
    logic [DATA_WIDTH-1:0]   addr_byte;
    logic [DATA_WIDTH-1:0]   fun_byte;

    assign addr_byte   = DATA_WIDTH'(addr_q);
    assign fun_byte    = DATA_WIDTH'(fun_q);
    assign tx_accept   = (state_q == StSend) && !TX_BUSY;
    assign last_accept = tx_accept && (idx_q == frame_last_idx(cmd_q));
    // Final byte: single-byte response, or second byte of a two-byte one
    assign rsp_final   = (state_q == StWaitRsp) && RX_VLD &&
                         ((rsp_len(cmd_q) == 1) || rx_cnt_q);
    assign tmr_clr     = last_accept || RX_VLD;
    assign tmr_en      = (state_q == StWaitRsp);

    rsp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rsp_timer (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .expire_o(tmr_expire)
    );

    // Select the frame byte addressed by the byte index; zero outside SEND
    always_comb begin
        tx_byte = '0;
        if (state_q == StSend) begin
            case (cmd_q)
                CmdWr: begin
                    case (idx_q)
                        2'd0:    tx_byte = DATA_WIDTH'(OPC_WR);
                        2'd1:    tx_byte = addr_byte;
                        default: tx_byte = wdata_q;
                    endcase
                end
                CmdRd: begin
                    tx_byte = (idx_q == 2'd0) ? DATA_WIDTH'(OPC_RD) : addr_byte;
                end
                CmdAluOp: begin
                    case (idx_q)
                        2'd0:    tx_byte = DATA_WIDTH'(OPC_ALU_OP);
                        2'd1:    tx_byte = opa_q;
                        2'd2:    tx_byte = opb_q;
                        default: tx_byte = fun_byte;
                    endcase
                end
                default: begin
                    tx_byte = (idx_q == 2'd0) ? DATA_WIDTH'(OPC_ALU_NOP) : fun_byte;
                end
            endcase
        end
    end

    // Main FSM: request capture, frame send, response collection and timeout
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StIdle;
            cmd_q      <= CmdWr;
            addr_q     <= '0;
            wdata_q    <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            fun_q      <= '0;
            idx_q      <= '0;
            rx_cnt_q   <= 1'b0;
            rx_lo_q    <= '0;
            rsp_data_q <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_to_q   <= 1'b0;
        end else begin
            rsp_vld_q <= 1'b0;
            rsp_to_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (REQ_VLD) begin
                        cmd_q   <= cmd_e'(REQ_CMD);
                        addr_q  <= REQ_ADDR;
                        wdata_q <= REQ_WR_DATA;
                        opa_q   <= REQ_OP_A;
                        opb_q   <= REQ_OP_B;
                        fun_q   <= REQ_FUN;
                        idx_q   <= '0;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (tx_accept) begin
                        idx_q <= idx_q + 2'd1;
                    end
                    if (last_accept) begin
                        rx_cnt_q <= 1'b0;
                        state_q  <= (cmd_q == CmdWr) ? StIdle : StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    // A final byte beats a coincident expiry
                    if (rsp_final) begin
                        if (rsp_len(cmd_q) == 1) begin
                            rsp_data_q <= {{DATA_WIDTH{1'b0}}, RX_DATA};
                        end else begin
                            rsp_data_q <= {RX_DATA, rx_lo_q};
                        end
                        rsp_vld_q <= 1'b1;
                        state_q   <= StIdle;
                    end else if (RX_VLD) begin
                        rx_lo_q  <= RX_DATA;
                        rx_cnt_q <= 1'b1;
                    end else if (tmr_expire) begin
                        rsp_to_q <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign REQ_RDY     = (state_q == StIdle);
    assign BUSY        = (state_q != StIdle);
    assign TX_VLD      = (state_q == StSend);
    assign TX_DATA     = tx_byte;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_VLD     = rsp_vld_q;
    assign RSP_TIMEOUT = rsp_to_q;

endmodule
